alu_decoder_mdu: RTL and testbench
==================================

ALU_DECODER_MDU -- requirements
Module: alu_decoder_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (>=4).
REQ-002 SHALL have parameter CTRL_W, default 4, width of aluController.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have aluOp  input  4  ALU instruction class.
REQ-006 SHALL have func  input  6  R-type function field.
REQ-007 SHALL have valid_i  input  1  aluOp/func/srcA/srcB valid this cycle.
REQ-008 SHALL have flush_i  input  1  abort any multi-cycle operation.
REQ-009 SHALL have srcA, srcB  input  WIDTH  operands.
REQ-010 SHALL have aluController  output  CTRL_W  combinational ALU control.
REQ-011 SHALL have busy_o  output  1  multi-cycle unit occupied, pipeline must stall.
REQ-012 SHALL have done_o  output  1  one-cycle pulse, hi/lo just updated.
REQ-013 SHALL have hi_o, lo_o  output  WIDTH  HI/LO registers.

Function
REQ-014 aluController SHALL be combinational: aluOp 0000->0000, 0001->0001, other non-0010 ->0000.
REQ-015 aluOp 0010 SHALL decode func: 100000 add->0000, 100010 sub->0001, 011100 mul->0010, 101010 slt->0011, 100100 and->0100, 100101 or->0101, 010000 mfhi->0110, 010010 mflo->0111, 011000 mult/011001 multu/011010 div/011011 divu->1000, any other->0000.
REQ-016 Start condition: valid_i & aluOp==0010 & func in {mult,multu,div,divu} & state IDLE & !flush_i; operands latched at that edge.
REQ-017 FSM states IDLE, MUL, DIV, FIX, DONE; IDLE->MUL (mult/multu) or DIV (div/divu) on start.
REQ-018 MUL/DIV SHALL run exactly WIDTH cycles of radix-2 shift-add / restoring shift-subtract on operand magnitudes (signed ops take absolute values; unsigned use raw values), then ->FIX.
REQ-019 FIX (1 cycle) SHALL apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign; ->DONE.
REQ-020 DONE SHALL load hi_o/lo_o (mult: hi=upper, lo=lower 2*WIDTH-bit product; div: hi=remainder, lo=quotient), assert done_o for that cycle only, ->IDLE.
REQ-021 Total latency: start edge at cycle 0, done_o high in cycle WIDTH+2; next start accepted in the same DONE cycle is NOT permitted (accepted from cycle WIDTH+3, state IDLE).
REQ-022 busy_o SHALL be high in MUL, DIV, FIX, DONE; low in IDLE.
REQ-023 Start requests while busy_o high SHALL be ignored; the requester holds valid_i until busy_o falls.
REQ-024 Divide by zero (srcB==0): lo = all ones, hi = srcA, full latency kept.
REQ-025 Signed overflow (srcA = most negative, srcB = -1, div): lo = srcA, hi = 0.
REQ-026 flush_i high in any state SHALL force IDLE next edge, done_o low, hi_o/lo_o unchanged; flush has priority over start.
REQ-027 hi_o/lo_o SHALL change only in DONE or at reset.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, internal counters/accumulators 0, including mid-operation.
REQ-029 After rst_n rises, a start SHALL be accepted on the first rising clk edge.

Verification
REQ-030 WIDTH=32, aluOp=0010, func=100010 -> aluController=0001, busy_o stays 0; func=111111 -> 0000.
REQ-031 mult srcA=-3 (FFFFFFFD), srcB=7 -> done_o at cycle 34, hi=FFFFFFFF, lo=FFFFFFEB, busy_o high cycles 1-34.
REQ-032 divu srcA=100, srcB=7 -> lo=14, hi=2; div srcA=-7, srcB=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 div srcB=0, srcA=55 -> lo=FFFFFFFF, hi=55; div 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-034 multu started, flush_i at cycle 10 -> busy_o low cycle 11, no done_o, hi/lo keep prior values; second start during busy ignored.
REQ-035 rst_n pulsed low at cycle 15 of div -> outputs zero asynchronously; new multu 5x6 after release -> lo=30, hi=0.

Source files
------------

// File: rtl/alu_decoder_mdu.sv
// ALU control decoder plus a multi-cycle multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add and divide is restoring shift-subtract, both on operand magnitudes.
module alu_decoder_mdu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        aluOp,
    input  logic [5:0]        func,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  srcA,
    input  logic [WIDTH-1:0]  srcB,
    output logic [CTRL_W-1:0] aluController,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_MUL   = 6'b011100;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               aneg_q, aneg_d;
    logic               div0_q, div0_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic [3:0] ctrl;

    always_comb begin
        ctrl = 4'b0000;
        case (aluOp)
            4'b0001: ctrl = 4'b0001;
            4'b0010: begin
                case (func)
                    F_ADD:   ctrl = 4'b0000;
                    F_SUB:   ctrl = 4'b0001;
                    F_MUL:   ctrl = 4'b0010;
                    F_SLT:   ctrl = 4'b0011;
                    F_AND:   ctrl = 4'b0100;
                    F_OR:    ctrl = 4'b0101;
                    F_MFHI:  ctrl = 4'b0110;
                    F_MFLO:  ctrl = 4'b0111;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = 4'b1000;
                    default: ctrl = 4'b0000;
                endcase
            end
            default: ctrl = 4'b0000;
        endcase
    end

    assign aluController = CTRL_W'(ctrl);

    logic op_md, op_signed, op_div, start;

    assign op_md     = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
    assign op_signed = (func == F_MULT) || (func == F_DIV);
    assign op_div    = (func == F_DIV) || (func == F_DIVU);
    assign start     = valid_i && (aluOp == 4'b0010) && op_md && (state_q == S_IDLE) && !flush_i;

    // p_q holds {hi, lo} of the product, or {remainder, dividend/quotient} while dividing
    logic [WIDTH:0]     mul_sum, div_sh, div_trial;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{p_q[0]}}};
        div_sh    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, b_q};
        prod_fix  = neg2_if(p_q, neg_q);
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        b_d     = b_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        div0_d  = div0_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = op_div ? S_DIV : S_MUL;
                        p_d     = {{WIDTH{1'b0}}, magnitude(srcA, op_signed)};
                        b_d     = magnitude(srcB, op_signed);
                        a_d     = srcA;
                        cnt_d   = '0;
                        neg_d   = op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        aneg_d  = op_signed && srcA[WIDTH-1];
                        div0_d  = (srcB == '0);
                        div_d   = op_div;
                    end
                end
                S_MUL: begin
                    p_d   = {mul_sum, p_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_FIX;
                end
                S_DIV: begin
                    if (!div_trial[WIDTH]) p_d = {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                    else                   p_d = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d = S_DONE;
                    if (!div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = neg_if(p_q[2*WIDTH-1:WIDTH], aneg_q);
                        lo_d = neg_if(p_q[WIDTH-1:0], neg_q);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            b_q     <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            b_q     <= b_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            div0_q  <= div0_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_decoder_mdu.sv
// Scoreboard bench for alu_decoder_mdu: decode table, multiply/divide results and latency,
// flush, back-to-back starts and asynchronous reset.
module tb_alu_decoder_mdu;
    localparam int W = 32;
    localparam int LAT = W + 2;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   aluOp;
    logic [5:0]   func;
    logic         valid_i;
    logic         flush_i;
    logic [W-1:0] srcA, srcB;
    logic [3:0]   aluController;
    logic         busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    always #5 clk = ~clk;

    alu_decoder_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .aluOp(aluOp), .func(func), .valid_i(valid_i),
        .flush_i(flush_i), .srcA(srcA), .srcB(srcB), .aluController(aluController),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t scb[$];
    res_t last_exp;
    int   checks = 0;
    int   failures = 0;

    // {aluOp, func, expected control}
    localparam logic [13:0] DEC_TBL [17] = '{
        {4'b0000, 6'b100010, 4'h0}, {4'b0001, 6'b100000, 4'h1}, {4'b0011, 6'b100010, 4'h0},
        {4'b1111, 6'b011000, 4'h0}, {4'b0010, 6'b100000, 4'h0}, {4'b0010, 6'b100010, 4'h1},
        {4'b0010, 6'b011100, 4'h2}, {4'b0010, 6'b101010, 4'h3}, {4'b0010, 6'b100100, 4'h4},
        {4'b0010, 6'b100101, 4'h5}, {4'b0010, 6'b010000, 4'h6}, {4'b0010, 6'b010010, 4'h7},
        {4'b0010, 6'b011000, 4'h8}, {4'b0010, 6'b011001, 4'h8}, {4'b0010, 6'b011010, 4'h8},
        {4'b0010, 6'b011011, 4'h8}, {4'b0010, 6'b111111, 4'h0}
    };

    function automatic res_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint sa, sbv, q, m;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = '0;
        case (f)
            F_MULT:  p = sa * sbv;
            F_MULTU: p = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sbv;
                    m = sa % sbv;
                    p = {m[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    // Issues one start, pushes the model result, then waits for done_o.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output bit timeout);
        scb.push_back(model(f, a, b));
        @(negedge clk);
        aluOp = 4'b0010; func = f; srcA = a; srcB = b; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        lat = 0; busy_cycles = 0; timeout = 1'b1; hi = '0; lo = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (busy_o) busy_cycles++;
            if (done_o) begin
                lat = n; hi = hi_o; lo = lo_o; timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; aluOp = 4'b0000; func = 6'b0;
        srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
        checks++; if (hi_o !== '0) begin failures++; $display("FAIL reset_hi got=%h want=0", hi_o); end
        checks++; if (lo_o !== '0) begin failures++; $display("FAIL reset_lo got=%h want=0", lo_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [13:0] e;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            e = DEC_TBL[i];
            aluOp = e[13:10]; func = e[9:4]; valid_i = 1'b0;
            #1;
            checks++;
            if (aluController !== e[3:0]) begin
                failures++;
                $display("FAIL decode[%0d] aluOp=%b func=%b got=%b want=%b", i, e[13:10], e[9:4], aluController, e[3:0]);
            end
        end
        @(negedge clk);
        aluOp = 4'b0010; func = 6'b100010; valid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL decode_sub_busy got=%b want=0", busy_o); end
        func = 6'b010010;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL decode_mflo_busy got=%b want=0", busy_o); end
        valid_i = 1'b0;
    endtask

    task automatic test_muldiv();
        logic [5:0]   fv [8] = '{F_MULT, F_DIVU, F_DIV, F_DIV, F_DIV, F_MULTU, F_MULT, F_DIV};
        logic [W-1:0] av [8] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'd55, 32'h8000_0000,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
        logic [W-1:0] bv [8] = '{32'd7, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE};
        int lat, bc; logic [W-1:0] hi, lo; bit to; res_t exp;
        for (int i = 0; i < 8; i++) begin
            run_op(fv[i], av[i], bv[i], lat, bc, hi, lo, to);
            exp = scb.pop_front();
            last_exp = exp;
            checks++;
            if (to) begin
                failures++; $display("FAIL muldiv_timeout[%0d] no done_o within 100 cycles", i);
                continue;
            end
            if (hi !== exp.hi || lo !== exp.lo) begin
                failures++;
                $display("FAIL muldiv_result[%0d] got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, exp.hi, exp.lo);
            end
            checks++; if (lat != LAT) begin failures++; $display("FAIL muldiv_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
            checks++; if (bc != LAT) begin failures++; $display("FAIL muldiv_busy_cycles[%0d] got=%0d want=%0d", i, bc, LAT); end
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++; $display("FAIL muldiv_pulse[%0d] got done=%b busy=%b want 0 0", i, done_o, busy_o);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc; logic [W-1:0] hi, lo, a, b; bit to; res_t exp; logic [5:0] f;
        for (int i = 0; i < 6; i++) begin
            f = F_MULT + 6'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 3) ? W'($urandom_range(1, 50)) : $urandom;
            run_op(f, a, b, lat, bc, hi, lo, to);
            exp = scb.pop_front();
            last_exp = exp;
            checks++;
            if (to || hi !== exp.hi || lo !== exp.lo || lat != LAT) begin
                failures++;
                $display("FAIL random[%0d] func=%b a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                         i, f, a, b, hi, lo, lat, exp.hi, exp.lo, LAT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        bit saw_done = 1'b0;
        @(negedge clk);
        aluOp = 4'b0010; func = F_MULTU; srcA = 32'hFFFF_FFFF; srcB = 32'd2; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
            if (n == 5) begin func = F_DIV; srcA = 32'd9; srcB = 32'd3; valid_i = 1'b1; end
            if (n == 6) valid_i = 1'b0;
            if (n == 10) flush_i = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b want=0", busy_o); end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL flush_done got=1 want=0"); end
        checks++;
        if (hi_o !== last_exp.hi || lo_o !== last_exp.lo) begin
            failures++;
            $display("FAIL flush_hold got hi=%h lo=%h want hi=%h lo=%h", hi_o, lo_o, last_exp.hi, last_exp.lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0; bit got = 1'b0; bit extra = 1'b0; res_t exp;
        scb.push_back(model(F_MULTU, 32'd5, 32'd6));
        @(negedge clk);
        aluOp = 4'b0010; func = F_MULTU; srcA = 32'd5; srcB = 32'd6; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            if (n == 5) begin func = F_DIVU; srcA = 32'd100; srcB = 32'd7; valid_i = 1'b1; end
            if (n == 6) valid_i = 1'b0;
            if (done_o) begin got = 1'b1; lat = n; end
        end
        exp = scb.pop_front();
        checks++;
        if (!got || hi_o !== exp.hi || lo_o !== exp.lo || lat != LAT) begin
            failures++;
            $display("FAIL b2b_first got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                     hi_o, lo_o, lat, exp.hi, exp.lo, LAT);
        end
        // request raised during the DONE cycle and held until accepted
        scb.push_back(model(F_MULT, 32'h1234_5678, 32'h0009_ABCD));
        func = F_MULT; srcA = 32'h1234_5678; srcB = 32'h0009_ABCD; valid_i = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_done_start busy=%b want=0", busy_o); end
        @(posedge clk);
        #1 valid_i = 1'b0;
        got = 1'b0; lat = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            if (done_o) begin got = 1'b1; lat = n; end
        end
        exp = scb.pop_front();
        last_exp = exp;
        checks++;
        if (!got || hi_o !== exp.hi || lo_o !== exp.lo || lat != LAT) begin
            failures++;
            $display("FAIL b2b_second got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                     hi_o, lo_o, lat, exp.hi, exp.lo, LAT);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) extra = 1'b1;
        end
        checks++; if (extra) begin failures++; $display("FAIL b2b_ignored_start extra done_o got=1 want=0"); end
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [W-1:0] hi, lo; bit to; res_t exp;
        @(negedge clk);
        aluOp = 4'b0010; func = F_DIV; srcA = 32'd1000; srcB = 32'd3; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int n = 1; n <= 15; n++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy_o, done_o, hi_o, lo_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(F_MULTU, 32'd5, 32'd6, lat, bc, hi, lo, to);
        exp = scb.pop_front();
        checks++;
        if (to || hi !== exp.hi || lo !== exp.lo || lat != LAT) begin
            failures++;
            $display("FAIL reset_restart got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                     hi, lo, lat, exp.hi, exp.lo, LAT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_muldiv();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
